// File: rtl/data_sram_arb_if.sv
// One master's request/response bundle toward the data SRAM arbiter.
// The master modport is the requester; the slave modport is the arbiter side.
interface data_sram_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              req;
  logic [DW/8-1:0]   wen;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic              gnt;
  logic              rvalid;
  logic [DW-1:0]     rdata;

  modport master (
    output req, wen, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/data_sram_arb.sv
// Round-robin arbiter sharing one synchronous data SRAM port between two masters.
// Grant and SRAM drive are combinational; the response returns one cycle after the grant.
module data_sram_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                resetn,
  data_sram_arb_if.slave      m0,
  data_sram_arb_if.slave      m1,
  output logic                sram_en,
  output logic [DW/8-1:0]     sram_wen,
  output logic [AW-1:0]       sram_addr,
  output logic [DW-1:0]       sram_wdata,
  input  logic [DW-1:0]       sram_rdata,
  output logic [CW-1:0]       conflict_cnt
);

  // last_id holds the most recent winner; reset to 1 so master 0 takes the first tie
  logic last_id;
  logic gnt0_p0;
  logic gnt1_p0;
  logic rsp_vld_p1;
  logic rsp_id_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Stage p0: combinational arbitration and SRAM drive
  always_comb begin
    gnt0_p0 = m0.req & (~m1.req | last_id);
    gnt1_p0 = m1.req & (~m0.req | ~last_id);
  end

  assign m0.gnt = gnt0_p0;
  assign m1.gnt = gnt1_p0;

  always_comb begin
    sram_en    = gnt0_p0 | gnt1_p0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt0_p0) begin
      sram_wen   = m0.wen;
      sram_addr  = m0.addr;
      sram_wdata = m0.wdata;
    end else if (gnt1_p0) begin
      sram_wen   = m1.wen;
      sram_addr  = m1.addr;
      sram_wdata = m1.wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_id      <= 1'b1;
      rsp_vld_p1   <= 1'b0;
      rsp_id_p1    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (sram_en) begin
        last_id <= gnt1_p0;
      end
      rsp_vld_p1 <= sram_en;
      rsp_id_p1  <= gnt1_p0;
      if (m0.req & m1.req) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

  // Stage p1: route the SRAM read word back to the master that owns the response
  always_comb begin
    m0.rvalid = rsp_vld_p1 & ~rsp_id_p1;
    m1.rvalid = rsp_vld_p1 &  rsp_id_p1;
    m0.rdata  = m0.rvalid ? sram_rdata : '0;
    m1.rdata  = m1.rvalid ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_data_sram_arb.sv
// Bench for data_sram_arb: directed scenarios plus a randomized run against a
// transaction-level model of arbitration order, responses and memory contents.
module tb_data_sram_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  data_sram_arb_if #(.AW(AW), .DW(DW)) m0_if ();
  data_sram_arb_if #(.AW(AW), .DW(DW)) m1_if ();
  data_sram_arb_if #(.AW(AW), .DW(DW)) s0_if ();
  data_sram_arb_if #(.AW(AW), .DW(DW)) s1_if ();

  logic            sram_en;
  logic [BW-1:0]   sram_wen;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata;
  logic [CW-1:0]   conflict_cnt;

  logic            s_sram_en;
  logic [BW-1:0]   s_sram_wen;
  logic [AW-1:0]   s_sram_addr;
  logic [DW-1:0]   s_sram_wdata;
  logic [3:0]      s_conflict_cnt;

  data_sram_arb #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .m0(m0_if), .m1(m1_if),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance sees the same request traffic
  assign s0_if.req = m0_if.req;  assign s0_if.wen = m0_if.wen;
  assign s0_if.addr = m0_if.addr; assign s0_if.wdata = m0_if.wdata;
  assign s1_if.req = m1_if.req;  assign s1_if.wen = m1_if.wen;
  assign s1_if.addr = m1_if.addr; assign s1_if.wdata = m1_if.wdata;

  data_sram_arb #(.AW(AW), .DW(DW), .CW(4)) dut_sat (
    .clk(clk), .resetn(resetn), .m0(s0_if), .m1(s1_if),
    .sram_en(s_sram_en), .sram_wen(s_sram_wen), .sram_addr(s_sram_addr),
    .sram_wdata(s_sram_wdata), .sram_rdata('0), .conflict_cnt(s_conflict_cnt)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Synchronous SRAM, write-first, 256 words; reloaded with its preset while reset is low
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 64) ? 32'hDEADBEEF : '0;
      sram_rdata <= '0;
    end else if (sram_en) begin
      if (|sram_wen) mem[sram_addr[9:2]] <= merge(mem[sram_addr[9:2]], sram_wdata, sram_wen);
      sram_rdata <= merge(mem[sram_addr[9:2]], sram_wdata, sram_wen);
    end
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic drive(input int m, input logic r, input logic [BW-1:0] w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_if.req = r; m0_if.wen = w; m0_if.addr = a; m0_if.wdata = d;
    end else begin
      m1_if.req = r; m1_if.wen = w; m1_if.addr = a; m1_if.wdata = d;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_cnt++;
    if ({m0_if.rvalid, m1_if.rvalid, m0_if.rdata, m1_if.rdata} !== '0)
      $display("FAIL reset_rsp: got rv=%b%b rdata=%h/%h expected all zero",
               m0_if.rvalid, m1_if.rvalid, m0_if.rdata, m1_if.rdata);
    else pass_cnt++;
    chk_cnt++;
    if ({conflict_cnt, sram_en, m0_if.gnt, m1_if.gnt} !== '0)
      $display("FAIL reset_ctl: got cnt=%0d en=%b gnt=%b%b expected zero",
               conflict_cnt, sram_en, m0_if.gnt, m1_if.gnt);
    else pass_cnt++;
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, '0, 32'h100, '0);
    #1;
    chk_cnt++;
    if ({m0_if.gnt, m1_if.gnt, sram_en, sram_wen, sram_addr} !== {3'b101, 4'h0, 32'h100})
      $display("FAIL single_grant: got gnt=%b%b en=%b wen=%h addr=%h expected 1 0 1 0 100",
               m0_if.gnt, m1_if.gnt, sram_en, sram_wen, sram_addr);
    else pass_cnt++;
    @(posedge clk); #1;
    idle();
    #1;
    chk_cnt++;
    if ({m0_if.rvalid, m1_if.rvalid, m0_if.rdata, m1_if.rdata} !== {2'b10, 32'hDEADBEEF, 32'h0})
      $display("FAIL single_rsp: got rv=%b%b rdata=%h/%h expected 10 deadbeef/0",
               m0_if.rvalid, m1_if.rvalid, m0_if.rdata, m1_if.rdata);
    else pass_cnt++;
    @(posedge clk); #2;
    chk_cnt++;
    if ({m0_if.rvalid, m1_if.rvalid} !== 2'b00)
      $display("FAIL single_pulse: got rv=%b%b expected 00", m0_if.rvalid, m1_if.rvalid);
    else pass_cnt++;
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, '0, 32'h100, '0);
      drive(1, 1'b1, '0, 32'h104, '0);
      #1;
      exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
      chk_cnt++;
      if ({m0_if.gnt, m1_if.gnt} !== exp_g)
        $display("FAIL tie_gnt%0d: got %b%b expected %b", c, m0_if.gnt, m1_if.gnt, exp_g);
      else pass_cnt++;
      if (c > 0) begin
        chk_cnt++;
        if ({m0_if.rvalid, m1_if.rvalid} !== ~exp_g)
          $display("FAIL tie_rv%0d: got %b%b expected %b", c, m0_if.rvalid, m1_if.rvalid, ~exp_g);
        else pass_cnt++;
      end
      if (c == 1 || c == 3) begin
        chk_cnt++;
        if (m0_if.rdata !== 32'hDEADBEEF)
          $display("FAIL tie_rdata%0d: got %h expected deadbeef", c, m0_if.rdata);
        else pass_cnt++;
      end
    end
    @(posedge clk); #1;
    idle();
    #1;
    chk_cnt++;
    if ({m0_if.rvalid, m1_if.rvalid, conflict_cnt} !== {2'b01, 16'd4})
      $display("FAIL tie_end: got rv=%b%b cnt=%0d expected 01 cnt=4",
               m0_if.rvalid, m1_if.rvalid, conflict_cnt);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    do_reset();
    @(posedge clk); #1;
    drive(1, 1'b1, 4'hF, 32'h40, 32'h12345678);
    #1;
    chk_cnt++;
    if ({m1_if.gnt, sram_en, sram_wen, sram_addr, sram_wdata} !== {2'b11, 4'hF, 32'h40, 32'h12345678})
      $display("FAIL wr_drive: got gnt=%b en=%b wen=%h addr=%h wdata=%h expected 1 1 f 40 12345678",
               m1_if.gnt, sram_en, sram_wen, sram_addr, sram_wdata);
    else pass_cnt++;
    @(posedge clk); #1;
    drive(1, 1'b1, 4'h0, 32'h40, 32'h0);
    #1;
    chk_cnt++;
    if ({m1_if.gnt, m1_if.rvalid, m0_if.rvalid, sram_wen} !== {3'b110, 4'h0})
      $display("FAIL wr_done: got gnt=%b rv1=%b rv0=%b wen=%h expected 1 1 0 0",
               m1_if.gnt, m1_if.rvalid, m0_if.rvalid, sram_wen);
    else pass_cnt++;
    @(posedge clk); #1;
    idle();
    #1;
    chk_cnt++;
    if ({m1_if.rvalid, m1_if.rdata, m0_if.rvalid} !== {1'b1, 32'h12345678, 1'b0})
      $display("FAIL rd_back: got rv1=%b rdata=%h rv0=%b expected 1 12345678 0",
               m1_if.rvalid, m1_if.rdata, m0_if.rvalid);
    else pass_cnt++;
  endtask

  task automatic test_byte_write();
    do_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, 4'b0010, 32'h80, 32'h0000AB00);
    #1;
    chk_cnt++;
    if ({m0_if.gnt, sram_wen} !== {1'b1, 4'b0010})
      $display("FAIL bw_drive: got gnt=%b wen=%b expected 1 0010", m0_if.gnt, sram_wen);
    else pass_cnt++;
    @(posedge clk); #1;
    drive(0, 1'b1, 4'b0000, 32'h80, 32'h0);
    @(posedge clk); #1;
    idle();
    #1;
    chk_cnt++;
    if ({m0_if.rvalid, m0_if.rdata} !== {1'b1, 32'h0000AB00})
      $display("FAIL bw_read: got rv=%b rdata=%h expected 1 0000ab00", m0_if.rvalid, m0_if.rdata);
    else pass_cnt++;
    chk_cnt++;
    if ({m1_if.gnt, m1_if.rvalid, m1_if.rdata} !== '0)
      $display("FAIL bw_m1_idle: got gnt=%b rv=%b rdata=%h expected zero",
               m1_if.gnt, m1_if.rvalid, m1_if.rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, '0, 32'h100, '0);
    @(posedge clk); #1;
    idle();
    resetn = 1'b0;
    #1;
    chk_cnt++;
    if ({m0_if.rvalid, m1_if.rvalid, m0_if.rdata} !== '0)
      $display("FAIL mid_clear: got rv=%b%b rdata=%h expected zero",
               m0_if.rvalid, m1_if.rvalid, m0_if.rdata);
    else pass_cnt++;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #2;
    chk_cnt++;
    if ({m0_if.rvalid, m1_if.rvalid} !== 2'b00)
      $display("FAIL mid_after: got rv=%b%b expected 00", m0_if.rvalid, m1_if.rvalid);
    else pass_cnt++;
    @(posedge clk); #1;
    drive(0, 1'b1, '0, 32'h100, '0);
    drive(1, 1'b1, '0, 32'h104, '0);
    #1;
    chk_cnt++;
    if ({m0_if.gnt, m1_if.gnt} !== 2'b10)
      $display("FAIL mid_tie: got %b%b expected 10", m0_if.gnt, m1_if.gnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, '0, 32'h100, '0);
      drive(1, 1'b1, '0, 32'h104, '0);
      @(posedge clk); #2;
      chk_cnt++;
      if (s_conflict_cnt !== 4'((c > 15) ? 15 : c))
        $display("FAIL sat_cnt%0d: got %0d expected %0d", c, s_conflict_cnt, (c > 15) ? 15 : c);
      else pass_cnt++;
      #1 idle();
    end
    chk_cnt++;
    if (conflict_cnt !== 16'd20)
      $display("FAIL wide_cnt: got %0d expected 20", conflict_cnt);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic            p_req  [2];
    logic [BW-1:0]   p_wen  [2];
    logic [AW-1:0]   p_addr [2];
    logic [DW-1:0]   p_wd   [2];
    logic [DW-1:0]   ref_mem [4];
    logic [DW-1:0]   exp_d;
    logic [DW-1:0]   rd_act;
    int              last_ref, win, exp_id, cnt_ref;
    bit              exp_v, exp_rd;
    do_reset();
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    for (int m = 0; m < 2; m++) p_req[m] = 1'b0;
    last_ref = 1; exp_v = 0; exp_id = 0; exp_rd = 0; exp_d = '0; cnt_ref = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (!p_req[m] && $urandom_range(0, 9) < 6) begin
          p_req[m]  = 1'b1;
          p_wen[m]  = ($urandom_range(0, 1) == 1) ? BW'($urandom_range(1, 15)) : '0;
          p_addr[m] = 32'h200 + 32'(4 * $urandom_range(0, 3));
          p_wd[m]   = $urandom;
        end
        drive(m, p_req[m], p_req[m] ? p_wen[m] : '0, p_req[m] ? p_addr[m] : '0,
              p_req[m] ? p_wd[m] : '0);
      end
      #1;
      if (p_req[0] && p_req[1]) win = (last_ref == 0) ? 1 : 0;
      else if (p_req[0])        win = 0;
      else if (p_req[1])        win = 1;
      else                      win = -1;
      chk_cnt++;
      if ({m0_if.gnt, m1_if.gnt} !== {win == 0, win == 1})
        $display("FAIL rnd_gnt c%0d: got %b%b expected winner %0d", c, m0_if.gnt, m1_if.gnt, win);
      else pass_cnt++;
      chk_cnt++;
      if (win < 0) begin
        if ({sram_en, sram_wen, sram_addr, sram_wdata} !== '0)
          $display("FAIL rnd_idle c%0d: got en=%b wen=%h addr=%h wd=%h expected zero",
                   c, sram_en, sram_wen, sram_addr, sram_wdata);
        else pass_cnt++;
      end else begin
        if ({sram_en, sram_wen, sram_addr, sram_wdata} !== {1'b1, p_wen[win], p_addr[win], p_wd[win]})
          $display("FAIL rnd_drive c%0d: got en=%b wen=%h addr=%h wd=%h expected 1 %h %h %h",
                   c, sram_en, sram_wen, sram_addr, sram_wdata, p_wen[win], p_addr[win], p_wd[win]);
        else pass_cnt++;
      end
      chk_cnt++;
      if ({m0_if.rvalid, m1_if.rvalid} !== {exp_v && exp_id == 0, exp_v && exp_id == 1})
        $display("FAIL rnd_rv c%0d: got %b%b expected valid=%0d id=%0d",
                 c, m0_if.rvalid, m1_if.rvalid, exp_v, exp_id);
      else pass_cnt++;
      if (exp_v && exp_rd) begin
        rd_act = (exp_id == 0) ? m0_if.rdata : m1_if.rdata;
        chk_cnt++;
        if (rd_act !== exp_d)
          $display("FAIL rnd_rdata c%0d: got %h expected %h", c, rd_act, exp_d);
        else pass_cnt++;
      end
      if (!m0_if.rvalid) begin
        chk_cnt++;
        if (m0_if.rdata !== '0) $display("FAIL rnd_rdata0_idle c%0d: got %h expected 0", c, m0_if.rdata);
        else pass_cnt++;
      end
      if (p_req[0] && p_req[1]) cnt_ref++;
      exp_v = (win >= 0);
      if (win >= 0) begin
        exp_id = win;
        exp_rd = (p_wen[win] == '0);
        exp_d  = ref_mem[p_addr[win][3:2]];
        if (!exp_rd) ref_mem[p_addr[win][3:2]] = merge(exp_d, p_wd[win], p_wen[win]);
        last_ref = win;
        p_req[win] = 1'b0;
      end
    end
    @(posedge clk); #1;
    idle();
    #1;
    chk_cnt++;
    if ({m0_if.rvalid, m1_if.rvalid} !== {exp_v && exp_id == 0, exp_v && exp_id == 1})
      $display("FAIL rnd_last_rv: got %b%b expected valid=%0d id=%0d",
               m0_if.rvalid, m1_if.rvalid, exp_v, exp_id);
    else pass_cnt++;
    chk_cnt++;
    if (conflict_cnt !== CW'(cnt_ref))
      $display("FAIL rnd_conflicts: got %0d expected %0d", conflict_cnt, cnt_ref);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write_read();
    test_byte_write();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
